alarm_entry_fsm: RTL and testbench

ALARM_ENTRY_FSM -- requirements
Module: alarm_entry_fsm

---
 rtl/alarm_ctrl_pkg.sv | 25 ++
 rtl/entry_timeout_cnt.sv | 32 +++
 rtl/alarm_entry_fsm.sv | 129 ++++++++++++
 tb/tb_alarm_entry_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the alarm-clock keypad entry controller:
// state encoding, entry limits and the digit-key qualifier.
package alarm_ctrl_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        KEY_STORED = 3'd1,
        KEY_WAITED = 3'd2,
        KEY_ENTRY  = 3'd3,
        SHOW_ALARM = 3'd4,
        SET_ALARM  = 3'd5,
        SET_TIME   = 3'd6
    } state_t;

    localparam int TIMEOUT_SECS  = 10;
    localparam int NUM_DIGITS    = 4;
    localparam int KEY_MAX       = 9;
    localparam int DIGIT_CNT_W   = 3;
    localparam int TIMEOUT_CNT_W = 4;

    function automatic logic is_digit(input logic [3:0] k);
        return k <= 4'(KEY_MAX);
    endfunction

endpackage

// File: rtl/entry_timeout_cnt.sv
// Entry inactivity timer: counts one_second pulses while enabled and flags
// the pulse that completes TIMEOUT_SECS seconds since the last clear.
module entry_timeout_cnt
    import alarm_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    input  logic one_second,
    output logic timeout
);

    localparam logic [TIMEOUT_CNT_W-1:0] LAST_COUNT = TIMEOUT_CNT_W'(TIMEOUT_SECS - 1);

    logic [TIMEOUT_CNT_W-1:0] count;

    assign timeout = enable && one_second && (count == LAST_COUNT);

    // Holds at LAST_COUNT so a timeout pulse swallowed by a higher-priority
    // transition still expires on the next pulse instead of wrapping.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && one_second && (count != LAST_COUNT)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alarm_entry_fsm.sv
// Keypad entry controller for an alarm clock: collects up to four digits and
// commits them to the alarm register or the time counter on a button press.
//
// state      | meaning
// SHOW_TIME  | idle, display shows current time
// KEY_STORED | shift strobe for the pressed digit
// KEY_WAITED | digit taken, waiting for key release
// KEY_ENTRY  | entry in progress, waiting for next key or button
// SHOW_ALARM | display shows alarm time while alarm_button held
// SET_ALARM  | load_new_alarm strobe
// SET_TIME   | load_new_time strobe
module alarm_entry_fsm
    import alarm_ctrl_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       key_valid,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       shift,
    output logic       load_new_alarm,
    output logic       load_new_time,
    output logic       show_new_time,
    output logic       show_a
);

    state_t                 state;
    state_t                 next_state;
    logic [DIGIT_CNT_W-1:0] digit_cnt;
    logic                   digits_full;
    logic                   timeout;
    logic                   timer_clear;
    logic                   timer_enable;

    assign digits_full  = (digit_cnt == DIGIT_CNT_W'(NUM_DIGITS));
    assign timer_enable = (state == KEY_WAITED) || (state == KEY_ENTRY);
    assign timer_clear  = (state == KEY_STORED) || (next_state == SHOW_TIME);

    entry_timeout_cnt u_timeout (
        .clock      (clock),
        .reset      (reset),
        .clear      (timer_clear),
        .enable     (timer_enable),
        .one_second (one_second),
        .timeout    (timeout)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= SHOW_TIME;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit_cnt <= '0;
        end else if (next_state == SHOW_TIME) begin
            digit_cnt <= '0;
        end else if ((state == KEY_STORED) && !digits_full) begin
            digit_cnt <= digit_cnt + 1'b1;
        end
    end

    // Outputs depend on state only; inputs steer next_state alone.
    always_comb begin
        next_state     = state;
        shift          = 1'b0;
        load_new_alarm = 1'b0;
        load_new_time  = 1'b0;
        show_new_time  = 1'b0;
        show_a         = 1'b0;

        unique case (state)
            SHOW_TIME: begin
                if (alarm_button && !key_valid) begin
                    next_state = SHOW_ALARM;
                end else if (key_valid && is_digit(key)) begin
                    next_state = KEY_STORED;
                end
            end
            KEY_STORED: begin
                shift      = 1'b1;
                next_state = KEY_WAITED;
            end
            KEY_WAITED: begin
                show_new_time = 1'b1;
                if (!key_valid) begin
                    next_state = KEY_ENTRY;
                end else if (timeout) begin
                    next_state = SHOW_TIME;
                end
            end
            KEY_ENTRY: begin
                show_new_time = 1'b1;
                if (alarm_button) begin
                    next_state = digits_full ? SET_ALARM : SHOW_TIME;
                end else if (time_button) begin
                    next_state = digits_full ? SET_TIME : SHOW_TIME;
                end else if (key_valid && is_digit(key)) begin
                    next_state = KEY_STORED;
                end else if (timeout) begin
                    next_state = SHOW_TIME;
                end
            end
            SHOW_ALARM: begin
                show_a = 1'b1;
                if (!alarm_button) begin
                    next_state = SHOW_TIME;
                end
            end
            SET_ALARM: begin
                load_new_alarm = 1'b1;
                next_state     = SHOW_TIME;
            end
            SET_TIME: begin
                load_new_time = 1'b1;
                next_state    = SHOW_TIME;
            end
            default: begin
                next_state = SHOW_TIME;
            end
        endcase
    end

endmodule

// File: tb/tb_alarm_entry_fsm.sv
// Self-checking bench for alarm_entry_fsm: directed scenarios plus random
// keypad/button traffic compared every cycle against a behavioural model.
module tb_alarm_entry_fsm;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       one_second = 1'b0;
    logic [3:0] key = 4'd0;
    logic       key_valid = 1'b0;
    logic       alarm_button = 1'b0;
    logic       time_button = 1'b0;
    logic       shift;
    logic       load_new_alarm;
    logic       load_new_time;
    logic       show_new_time;
    logic       show_a;

    int errors = 0;
    int checks = 0;
    int n_shift, n_la, n_lt, n_sa;

    // Model of what the controller is doing, in terms of pending strobes and
    // entry progress rather than named states.
    bit m_shift, m_la, m_lt, m_view, m_entry, m_held;
    int m_digits, m_secs;

    alarm_entry_fsm dut (
        .clock          (clock),
        .reset          (reset),
        .one_second     (one_second),
        .key            (key),
        .key_valid      (key_valid),
        .alarm_button   (alarm_button),
        .time_button    (time_button),
        .shift          (shift),
        .load_new_alarm (load_new_alarm),
        .load_new_time  (load_new_time),
        .show_new_time  (show_new_time),
        .show_a         (show_a)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_idle();
        m_shift = 0; m_la = 0; m_lt = 0; m_view = 0;
        m_entry = 0; m_held = 0; m_digits = 0; m_secs = 0;
    endtask

    task automatic m_step();
        bit tick, expire, press;
        int d;
        tick   = one_second;
        press  = key_valid && (key < 10);
        expire = tick && (m_secs >= 9);
        if (m_shift) begin
            m_shift  = 0;
            m_digits = (m_digits < 4) ? m_digits + 1 : 4;
            m_secs   = 0;
            m_entry  = 1;
            m_held   = 1;
        end else if (m_la || m_lt) begin
            m_idle();
        end else if (m_view) begin
            if (!alarm_button) m_idle();
        end else if (m_entry) begin
            if (m_held) begin
                if (!key_valid) begin
                    m_held = 0;
                    m_secs += int'(tick);
                end else if (expire) begin
                    m_idle();
                end else begin
                    m_secs += int'(tick);
                end
            end else if (alarm_button || time_button) begin
                d = m_digits;
                m_idle();
                if (d == 4) begin
                    if (alarm_button) m_la = 1;
                    else m_lt = 1;
                end
            end else if (press) begin
                m_entry = 0;
                m_shift = 1;
            end else if (expire) begin
                m_idle();
            end else begin
                m_secs += int'(tick);
            end
        end else begin
            if (alarm_button && !key_valid) m_view = 1;
            else if (press) m_shift = 1;
        end
    endtask

    task automatic check_outputs();
        chk("shift", shift, m_shift);
        chk("load_new_alarm", load_new_alarm, m_la);
        chk("load_new_time", load_new_time, m_lt);
        chk("show_new_time", show_new_time, m_entry);
        chk("show_a", show_a, m_view);
        chk("strobe_exclusive", logic'((int'(shift) + int'(load_new_alarm) + int'(load_new_time)) <= 1), 1'b1);
        chk("display_exclusive", logic'(show_new_time && show_a), 1'b0);
        n_shift += int'(shift === 1'b1);
        n_la    += int'(load_new_alarm === 1'b1);
        n_lt    += int'(load_new_time === 1'b1);
        n_sa    += int'(show_a === 1'b1);
    endtask

    task automatic clear_tallies();
        n_shift = 0; n_la = 0; n_lt = 0; n_sa = 0;
    endtask

    task automatic cycle(input bit os, input logic [3:0] k, input bit kv, input bit ab, input bit tbn);
        one_second = os; key = k; key_valid = kv; alarm_button = ab; time_button = tbn;
        @(posedge clock);
        m_step();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic press(input logic [3:0] k);
        repeat (3) cycle(0, k, 1, 0, 0);
        cycle(0, 4'd0, 0, 0, 0);
    endtask

    task automatic seconds(input int n);
        repeat (n) begin
            cycle(1, 4'd0, 0, 0, 0);
            cycle(0, 4'd0, 0, 0, 0);
        end
    endtask

    initial begin
        bit r_os, r_kv, r_ab, r_tb;
        logic [3:0] r_key;

        clear_tallies();
        m_idle();
        #2;
        check_outputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;

        // Four digits then alarm_button commits the alarm
        clear_tallies();
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        cycle(0, 4'd0, 0, 1, 0);
        chk("req028_load_alarm_now", load_new_alarm, 1'b1);
        cycle(0, 4'd0, 0, 0, 0);
        cycle(0, 4'd0, 0, 0, 0);
        chk_int("req028_shift_pulses", n_shift, 4);
        chk_int("req028_load_alarm_pulses", n_la, 1);
        chk("req028_idle_after", show_new_time, 1'b0);

        // Two digits then time_button abandons without loading
        clear_tallies();
        press(4'd0); press(4'd7);
        cycle(0, 4'd0, 0, 0, 1);
        cycle(0, 4'd0, 0, 0, 0);
        chk_int("req029_shift_pulses", n_shift, 2);
        chk_int("req029_load_time_pulses", n_lt, 0);
        chk("req029_idle_after", show_new_time, 1'b0);

        // Timeout on the 10th one_second pulse
        clear_tallies();
        press(4'd5);
        seconds(8);
        cycle(1, 4'd0, 0, 0, 0);
        chk("req030_pulse9_still_entry", show_new_time, 1'b1);
        cycle(0, 4'd0, 0, 0, 0);
        cycle(1, 4'd0, 0, 0, 0);
        chk("req030_pulse10_exit", show_new_time, 1'b0);

        // Alarm display while held; out-of-range key ignored
        clear_tallies();
        repeat (5) cycle(0, 4'd0, 0, 1, 0);
        cycle(0, 4'd0, 0, 0, 0);
        chk_int("req031_show_a_cycles", n_sa, 5);
        chk("req031_show_a_released", show_a, 1'b0);
        repeat (3) cycle(0, 4'd12, 1, 0, 0);
        cycle(0, 4'd0, 0, 0, 0);
        chk_int("req031_key12_shifts", n_shift, 0);

        // Button wins over simultaneous timeout
        clear_tallies();
        press(4'd9); press(4'd8); press(4'd7); press(4'd6);
        seconds(9);
        cycle(1, 4'd0, 0, 1, 0);
        chk("req032_load_alarm", load_new_alarm, 1'b1);
        cycle(0, 4'd0, 0, 0, 0);

        // Reset during entry discards it immediately
        press(4'd3); press(4'd8);
        chk("req027_in_entry", show_new_time, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        m_idle();
        chk("req027_rst_shift", shift, 1'b0);
        chk("req027_rst_show_new_time", show_new_time, 1'b0);
        chk("req027_rst_show_a", show_a, 1'b0);
        chk("req027_rst_loads", logic'(load_new_alarm || load_new_time), 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        clear_tallies();
        cycle(0, 4'd0, 0, 0, 1);
        repeat (3) cycle(0, 4'd0, 0, 0, 0);
        chk_int("req027_no_load_after", n_la + n_lt, 0);

        // Random traffic
        r_kv = 0;
        r_key = 4'd0;
        for (int i = 0; i < 3000; i++) begin
            r_os = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) begin
                r_kv = !r_kv;
                if (r_kv) r_key = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15))
                                                              : 4'($urandom_range(0, 9));
            end
            r_ab = ($urandom_range(0, 14) == 0);
            r_tb = ($urandom_range(0, 14) == 0);
            cycle(r_os, r_key, r_kv, r_ab, r_tb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
